n64_poll_controller: RTL and testbench

N64_POLL_CONTROLLER -- requirements
Module: n64_poll_controller

---
 rtl/n64_poll_controller.sv | 181 ++++++++++++++++++
 tb/tb_n64_poll_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_poll_controller.sv
// n64_poll_controller: polls an N64 controller by sending command 0x01 and a stop bit on the
//    one-wire line, then arms an external 32-bit reader and captures its word into buttons.
// Latency: line_oe asserts the cycle after start; rd_enable follows 8*4*US_TICKS + 3*US_TICKS
//    cycles of line time; data_valid/timeout_err are registered one cycle after completion/expiry.
// Backpressure: none; a start or auto trigger arriving while busy is dropped, never queued.
// Ports: clk, rst_n (async, active low); start request; line_oe (1 = pull line low);
//    rd_enable/rd_working/rd_data reader handshake; buttons, data_valid, timeout_err, busy.
// Build option: define N64_POLL_AUTO_EN to add a free-running POLL_TICKS auto-poll timer.
module n64_poll_controller #(
   parameter int US_TICKS      = 100,
   parameter int TIMEOUT_TICKS = 20000,
   parameter int POLL_TICKS    = 1666666
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        line_oe,
   output logic        rd_enable,
   input  logic        rd_working,
   input  logic [31:0] rd_data,
   output logic [31:0] buttons,
   output logic        data_valid,
   output logic        timeout_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SEND       = 3'd1,
      STOP       = 3'd2,
      ARM        = 3'd3,
      WAIT_START = 3'd4,
      WAIT_DONE  = 3'd5
   } state_t;

   localparam int PW = $clog2(4 * US_TICKS);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [7:0]    CMD_BYTE  = 8'h01;
   localparam logic [PW-1:0] BIT_LAST  = PW'(4 * US_TICKS - 1);
   localparam logic [PW-1:0] STOP_LAST = PW'(3 * US_TICKS - 1);
   localparam logic [PW-1:0] SHORT_LOW = PW'(US_TICKS);
   localparam logic [PW-1:0] LONG_LOW  = PW'(3 * US_TICKS);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

   state_t        state, state_nxt;
   logic [PW-1:0] phase;      // cycle within the current bit / stop slot
   logic [2:0]    bit_idx;    // 0 = MSB of the command byte
   logic [TW-1:0] tcnt;       // cycles spent waiting on the reader
   logic          trigger;
   logic          cmd_bit;
   logic          complete;
   logic          expire;

`ifdef N64_POLL_AUTO_EN
   localparam int AW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam logic [AW-1:0] POLL_LAST = AW'(POLL_TICKS - 1);

   logic [AW-1:0] poll_cnt;
   logic          poll_hit;

   assign poll_hit = (poll_cnt == POLL_LAST);

   // Free-running from reset release; a hit while busy is simply lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_hit ? '0 : poll_cnt + AW'(1);
      end
   end

   assign trigger = start | poll_hit;
`else
   // The auto-poll period has no effect in this build.
   logic poll_unused;
   assign poll_unused = (POLL_TICKS > 0);
   assign trigger     = start;
`endif

   // bit_idx counts up from the MSB, so the byte position is its complement.
   assign cmd_bit = CMD_BYTE[~bit_idx];
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      line_oe   = 1'b0;
      rd_enable = 1'b0;
      complete  = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) state_nxt = SEND;
         end
         SEND: begin
            // '1' is a short low pulse, '0' a long one; both slots are 4 us.
            line_oe = cmd_bit ? (phase < SHORT_LOW) : (phase < LONG_LOW);
            if (phase == BIT_LAST && bit_idx == 3'd7) state_nxt = STOP;
         end
         STOP: begin
            line_oe = (phase < SHORT_LOW);
            if (phase == STOP_LAST) state_nxt = ARM;
         end
         ARM: begin
            rd_enable = 1'b1;
            state_nxt = WAIT_START;
         end
         WAIT_START: begin
            if (tcnt == TO_LAST) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end else if (rd_working) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // Completion is checked first so it wins a tie with the timeout.
            if (!rd_working) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else if (tcnt == TO_LAST) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= '0;
         bit_idx     <= '0;
         tcnt        <= '0;
         buttons     <= '0;
         data_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            SEND: begin
               if (phase == BIT_LAST) begin
                  phase   <= '0;
                  bit_idx <= bit_idx + 3'd1;   // wraps to 0 after the last bit
               end else begin
                  phase <= phase + PW'(1);
               end
            end
            STOP: begin
               phase <= (phase == STOP_LAST) ? '0 : phase + PW'(1);
            end
            ARM: begin
               tcnt <= '0;
            end
            WAIT_START, WAIT_DONE: begin
               tcnt <= tcnt + TW'(1);
               if (complete) begin
                  buttons    <= rd_data;
                  data_valid <= 1'b1;
               end else if (expire) begin
                  timeout_err <= 1'b1;
               end
            end
            default: begin
               phase   <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_n64_poll_controller.sv
// tb_n64_poll_controller: drives polls into n64_poll_controller with a behavioural reader whose
//    response delay, busy length and word are chosen per poll, and predicts line pulse widths,
//    handshake timing and the success/timeout outcome from the protocol rules.
module tb_n64_poll_controller;

   localparam int US       = 4;
   localparam int TO       = 200;
   localparam int POLL     = 2000;
   localparam int SEND_CYC = 8 * 4 * US + 3 * US;   // command byte plus stop slot
   localparam int BUDGET   = SEND_CYC + TO + 20;
   localparam logic [7:0] CMD = 8'h01;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        line_oe;
   logic        rd_enable;
   logic        rd_working;
   logic [31:0] rd_data;
   logic [31:0] buttons;
   logic        data_valid;
   logic        timeout_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor state (cycle-indexed observations).
   int          cyc;
   int          run;
   int          pulses[$];
   int          rise_q[$];
   int          en_cnt, en_cyc, dv_cnt, dv_cyc, to_cnt, to_cyc;
   logic [31:0] dv_word;

   // Reader model configuration.
   bit          armed;
   bit          r_respond;
   int          r_d, r_len;
   logic [31:0] r_word;

   n64_poll_controller #(
      .US_TICKS     (US),
      .TIMEOUT_TICKS(TO),
      .POLL_TICKS   (POLL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .line_oe    (line_oe),
      .rd_enable  (rd_enable),
      .rd_working (rd_working),
      .rd_data    (rd_data),
      .buttons    (buttons),
      .data_valid (data_valid),
      .timeout_err(timeout_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   task automatic clear_counts();
      pulses.delete();
      rise_q.delete();
      run    = 0;
      en_cnt = 0; en_cyc = -1;
      dv_cnt = 0; dv_cyc = -1;
      to_cnt = 0; to_cyc = -1;
      armed  = 1'b0;
   endtask

   // Advance one cycle, observe outputs #1 after the edge, then drive the reader for this cycle.
   task automatic step();
      int rel;
      @(posedge clk);
      #1;
      cyc++;
      if (line_oe) begin
         if (run == 0) rise_q.push_back(cyc);
         run++;
      end else if (run != 0) begin
         pulses.push_back(run);
         run = 0;
      end
      if (rd_enable)   begin en_cnt++; en_cyc = cyc; armed = 1'b1; end
      if (data_valid)  begin dv_cnt++; dv_cyc = cyc; dv_word = buttons; end
      if (timeout_err) begin to_cnt++; to_cyc = cyc; end
      if (armed) begin
         rel        = cyc - en_cyc;
         rd_working = r_respond && rel >= r_d && rel < r_d + r_len;
         rd_data    = (r_respond && rel >= r_d + r_len) ? r_word : $urandom();
      end else begin
         rd_working = 1'b0;
         rd_data    = $urandom();
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      start      = 1'b0;
      rd_working = 1'b0;
      rd_data    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_counts();
      cyc = 0;
   endtask

   task automatic fire_start(output int sc);
      clear_counts();
      sc    = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(output int fall, output bit ok);
      ok   = 1'b0;
      fall = -1;
      for (int i = 0; i < BUDGET; i++) begin
         if (!busy) begin
            ok   = 1'b1;
            fall = cyc;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (line_oe !== 1'b0)     begin n_fail++; $display("FAIL reset_line_oe: got %b want 0", line_oe); end
      n_checks++; if (rd_enable !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_enable: got %b want 0", rd_enable); end
      n_checks++; if (buttons !== 32'h0)    begin n_fail++; $display("FAIL reset_buttons: got %h want 0", buttons); end
      n_checks++; if (data_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic_poll();
      int sc, fall, exp_arm;
      bit ok;
      do_reset();
      step(); step();
      r_respond = 1'b1; r_d = 3; r_len = 40; r_word = 32'h8000_00FF;
      fire_start(sc);
      n_checks++; if (busy !== 1'b1 || line_oe !== 1'b1) begin n_fail++; $display("FAIL start_latency: busy=%b line_oe=%b want 1,1", busy, line_oe); end
      wait_idle(fall, ok);
      step(); step();
      exp_arm = sc + 1 + SEND_CYC;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_idle: busy still %b after %0d cycles", busy, BUDGET); end
      n_checks++; if (pulses.size() !== 9) begin n_fail++; $display("FAIL basic_pulse_count: got %0d want 9", pulses.size()); end
      for (int i = 0; i < 9 && i < pulses.size(); i++) begin
         int e;
         if (i == 8) e = US;
         else e = CMD[7-i] ? US : 3 * US;
         n_checks++; if (pulses[i] !== e) begin n_fail++; $display("FAIL basic_pulse[%0d]: got %0d want %0d", i, pulses[i], e); end
      end
      n_checks++; if (en_cnt !== 1)       begin n_fail++; $display("FAIL basic_rd_enable_count: got %0d want 1", en_cnt); end
      n_checks++; if (en_cyc !== exp_arm) begin n_fail++; $display("FAIL basic_rd_enable_cycle: got %0d want %0d", en_cyc, exp_arm); end
      n_checks++; if (dv_cnt !== 1)       begin n_fail++; $display("FAIL basic_dv_count: got %0d want 1", dv_cnt); end
      n_checks++; if (dv_cyc !== exp_arm + r_d + r_len + 1) begin n_fail++; $display("FAIL basic_dv_cycle: got %0d want %0d", dv_cyc, exp_arm + r_d + r_len + 1); end
      n_checks++; if (dv_word !== 32'h8000_00FF) begin n_fail++; $display("FAIL basic_dv_word: got %h want 800000ff", dv_word); end
      n_checks++; if (buttons !== 32'h8000_00FF) begin n_fail++; $display("FAIL basic_buttons: got %h want 800000ff", buttons); end
      n_checks++; if (to_cnt !== 0)       begin n_fail++; $display("FAIL basic_no_timeout: got %0d want 0", to_cnt); end
      n_checks++; if (fall !== dv_cyc)    begin n_fail++; $display("FAIL basic_busy_fall: got %0d want %0d", fall, dv_cyc); end
   endtask

   task automatic test_timeout();
      int sc, fall, exp_arm;
      bit ok;
      logic [31:0] prev;
      prev      = buttons;
      r_respond = 1'b0;
      fire_start(sc);
      wait_idle(fall, ok);
      step(); step();
      exp_arm = sc + 1 + SEND_CYC;
      n_checks++; if (!ok)           begin n_fail++; $display("FAIL to_idle: busy still %b", busy); end
      n_checks++; if (en_cnt !== 1)  begin n_fail++; $display("FAIL to_rd_enable_count: got %0d want 1", en_cnt); end
      n_checks++; if (to_cnt !== 1)  begin n_fail++; $display("FAIL to_count: got %0d want 1", to_cnt); end
      n_checks++; if (to_cyc !== exp_arm + TO + 1) begin n_fail++; $display("FAIL to_cycle: got %0d want %0d", to_cyc, exp_arm + TO + 1); end
      n_checks++; if (dv_cnt !== 0)  begin n_fail++; $display("FAIL to_no_dv: got %0d want 0", dv_cnt); end
      n_checks++; if (buttons !== prev) begin n_fail++; $display("FAIL to_buttons_kept: got %h want %h", buttons, prev); end
      n_checks++; if (fall !== exp_arm + TO + 1) begin n_fail++; $display("FAIL to_busy_fall: got %0d want %0d", fall, exp_arm + TO + 1); end
   endtask

   task automatic test_start_during_send();
      int sc, fall;
      bit ok;
      do_reset();
      r_respond = 1'b1; r_d = $urandom_range(1, 10); r_len = $urandom_range(1, 30); r_word = $urandom();
      fire_start(sc);
      for (int k = 0; k < 5; k++) begin
         repeat ($urandom_range(1, 20)) step();
         start = 1'b1;
         step();
         start = 1'b0;
      end
      wait_idle(fall, ok);
      repeat (40) step();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL dup_idle: busy still %b", busy); end
      n_checks++; if (pulses.size() !== 9) begin n_fail++; $display("FAIL dup_pulse_count: got %0d want 9", pulses.size()); end
      for (int i = 0; i < 9 && i < pulses.size(); i++) begin
         int e;
         if (i == 8) e = US;
         else e = CMD[7-i] ? US : 3 * US;
         n_checks++; if (pulses[i] !== e) begin n_fail++; $display("FAIL dup_pulse[%0d]: got %0d want %0d", i, pulses[i], e); end
      end
      n_checks++; if (en_cnt !== 1) begin n_fail++; $display("FAIL dup_rd_enable_count: got %0d want 1", en_cnt); end
      n_checks++; if (dv_cnt !== 1) begin n_fail++; $display("FAIL dup_dv_count: got %0d want 1", dv_cnt); end
      n_checks++; if (buttons !== r_word) begin n_fail++; $display("FAIL dup_buttons: got %h want %h", buttons, r_word); end
   endtask

   task automatic test_reset_mid_send();
      int sc, fall;
      bit ok;
      do_reset();
      r_respond = 1'b1; r_d = 2; r_len = 10; r_word = $urandom() | 32'h1;
      fire_start(sc);
      wait_idle(fall, ok);
      step();
      n_checks++; if (!ok || buttons !== r_word) begin n_fail++; $display("FAIL mid_setup_buttons: got %h want %h", buttons, r_word); end
      fire_start(sc);
      while (cyc < sc + 1 + 2 * 4 * US + 5) step();
      n_checks++; if (line_oe !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_third_bit: line_oe=%b busy=%b want 1,1", line_oe, busy); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++; if (line_oe !== 1'b0)    begin n_fail++; $display("FAIL mid_line_release: got %b want 0", line_oe); end
      n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_checks++; if (buttons !== 32'h0)   begin n_fail++; $display("FAIL mid_buttons: got %h want 0", buttons); end
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_data_valid: got %b want 0", data_valid); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_counts();
      cyc = 0;
      repeat (300) step();
      n_checks++; if (dv_cnt !== 0 || en_cnt !== 0) begin n_fail++; $display("FAIL mid_no_response: dv=%0d rd_enable=%0d want 0,0", dv_cnt, en_cnt); end
      n_checks++; if (pulses.size() !== 0 || run !== 0) begin n_fail++; $display("FAIL mid_no_restart: pulses=%0d run=%0d want 0,0", pulses.size(), run); end
      n_checks++; if (buttons !== 32'h0) begin n_fail++; $display("FAIL mid_buttons_after: got %h want 0", buttons); end
   endtask

   task automatic test_completion_timeout_tie();
      int sc, fall, exp_arm;
      bit ok;
      logic [31:0] w1;
      do_reset();
      // Reader drops busy on the last cycle of the wait window.
      r_respond = 1'b1; r_d = $urandom_range(1, 60); r_len = TO - r_d; r_word = $urandom();
      w1 = r_word;
      fire_start(sc);
      wait_idle(fall, ok);
      step();
      exp_arm = sc + 1 + SEND_CYC;
      n_checks++; if (dv_cnt !== 1 || to_cnt !== 0) begin n_fail++; $display("FAIL tie_winner: dv=%0d timeout=%0d want 1,0", dv_cnt, to_cnt); end
      n_checks++; if (dv_cyc !== exp_arm + TO + 1) begin n_fail++; $display("FAIL tie_dv_cycle: got %0d want %0d", dv_cyc, exp_arm + TO + 1); end
      n_checks++; if (buttons !== w1) begin n_fail++; $display("FAIL tie_buttons: got %h want %h", buttons, w1); end
      // One cycle later than the window: the timeout must win.
      r_d = $urandom_range(1, 60); r_len = TO + 1 - r_d; r_word = ~w1;
      fire_start(sc);
      wait_idle(fall, ok);
      step();
      exp_arm = sc + 1 + SEND_CYC;
      n_checks++; if (dv_cnt !== 0 || to_cnt !== 1) begin n_fail++; $display("FAIL late_winner: dv=%0d timeout=%0d want 0,1", dv_cnt, to_cnt); end
      n_checks++; if (to_cyc !== exp_arm + TO + 1) begin n_fail++; $display("FAIL late_to_cycle: got %0d want %0d", to_cyc, exp_arm + TO + 1); end
      n_checks++; if (buttons !== w1) begin n_fail++; $display("FAIL late_buttons_kept: got %h want %h", buttons, w1); end
   endtask

   task automatic test_back_to_back_random();
      int sc, fall, exp_arm, exp_end;
      bit ok, success;
      logic [31:0] exp_btn;
      exp_btn = '0;
      for (int it = 0; it < 9; it++) begin
         if (it % 3 == 0) begin
            do_reset();
            exp_btn = '0;
         end
         r_respond = ($urandom_range(0, 3) != 0);
         r_d       = $urandom_range(1, 80);
         r_len     = $urandom_range(1, 160);
         r_word    = $urandom();
         success   = r_respond && (r_d + r_len <= TO);
         fire_start(sc);
         wait_idle(fall, ok);
         exp_arm = sc + 1 + SEND_CYC;
         exp_end = exp_arm + (success ? r_d + r_len : TO) + 1;
         if (success) exp_btn = r_word;
         n_checks++; if (!ok || fall !== exp_end) begin n_fail++; $display("FAIL rnd%0d_end_cycle: got %0d want %0d", it, fall, exp_end); end
         n_checks++; if (dv_cnt !== (success ? 1 : 0) || to_cnt !== (success ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_outcome: dv=%0d timeout=%0d success=%0d", it, dv_cnt, to_cnt, success); end
         n_checks++; if (buttons !== exp_btn) begin n_fail++; $display("FAIL rnd%0d_buttons: got %h want %h", it, buttons, exp_btn); end
         n_checks++; if (pulses.size() !== 9 || en_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_frame: pulses=%0d rd_enable=%0d want 9,1", it, pulses.size(), en_cnt); end
      end
   endtask

   task automatic test_auto_poll();
      do_reset();
      r_respond = 1'b0;
`ifdef N64_POLL_AUTO_EN
      while (cyc < 2 * POLL + 5) step();
      n_checks++; if (rise_q.size() < 10) begin n_fail++; $display("FAIL auto_rises: got %0d want >=10", rise_q.size()); end
      else begin
         n_checks++; if (rise_q[0] !== POLL)     begin n_fail++; $display("FAIL auto_first: got %0d want %0d", rise_q[0], POLL); end
         n_checks++; if (rise_q[9] !== 2 * POLL) begin n_fail++; $display("FAIL auto_second: got %0d want %0d", rise_q[9], 2 * POLL); end
      end
      n_checks++; if (en_cnt !== 1 || to_cnt !== 1) begin n_fail++; $display("FAIL auto_first_poll: rd_enable=%0d timeout=%0d want 1,1", en_cnt, to_cnt); end
`else
      repeat (10000) step();
      n_checks++; if (rise_q.size() !== 0 || run !== 0) begin n_fail++; $display("FAIL quiet_line: rises=%0d run=%0d want 0,0", rise_q.size(), run); end
      n_checks++; if (en_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL quiet_idle: rd_enable=%0d busy=%b want 0,0", en_cnt, busy); end
`endif
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      rd_working = 1'b0;
      rd_data    = '0;
      cyc        = 0;
      dv_word    = '0;
      r_respond  = 1'b0;
      r_d        = 1;
      r_len      = 1;
      r_word     = '0;
      clear_counts();
      test_reset();
      test_basic_poll();
      test_timeout();
      test_start_during_send();
      test_reset_mid_send();
      test_completion_timeout_tie();
      test_back_to_back_random();
      test_auto_poll();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
